maze_solve: RTL and testbench
=============================

Name: maze_solve

Overview:
- Wall-following maze solver that sits directly upstream of the navigation state machine.
- Decides each turn and forward move. It issues strt_hdng/strt_mv pulses, desired heading and stp_lft/stp_rght, and consumes mv_cmplt.
- Supports left-affinity or right-affinity wall following and stops when the magnet/solution detect (sol_cmplt) is seen.

Parameters:
HDNG_N, 12'h000, desired-heading code for north (initial heading)
HDNG_W, 12'h3FF, heading code for west
HDNG_S, 12'h7FF, heading code for south
HDNG_E, 12'hC00, heading code for east

Ports:
clk  input  1  50MHz clock
rst_n  input  1  asynchronous active-low reset
strt_solve  input  1  one-cycle pulse; begin solving (ignored unless in IDLE or DONE)
lft_affinity  input  1  1=left-wall follower, 0=right; sampled only on accepted strt_solve
lft_opn  input  1  IR: left opening
rght_opn  input  1  IR: right opening
frwrd_opn  input  1  IR: forward open
mv_cmplt  input  1  one-cycle pulse from navigator: heading or move complete
sol_cmplt  input  1  level; maze exit/magnet detected
strt_hdng  output  1  one-cycle pulse: start heading change to dsrd_hdng
strt_mv  output  1  one-cycle pulse: start forward move
stp_lft  output  1  registered; = affinity==left during solve
stp_rght  output  1  registered; = affinity==right during solve
dsrd_hdng  output  12  desired heading code, registered
solved  output  1  level; set on completion, cleared by next accepted strt_solve

Behaviour:
- Reset values: state=IDLE; dir=N; dsrd_hdng=HDNG_N; strt_hdng=0; strt_mv=0; stp_lft=0; stp_rght=0; solved=0; affinity register=0.
- dir is a 2-bit register: 0=N, 1=W, 2=S, 3=E. dsrd_hdng is registered from dir via the parameter codes and updates in the same edge as dir.
- Turn arithmetic, mod 4 with wrap: left = dir+1; right = dir-1; reverse = dir+2. Examples: E+1→N, N-1→E, W+2→E.
- States:
  - IDLE → ST_MV on strt_solve.
    - Latch affinity.
    - Set stp_lft=lft_affinity, stp_rght=~lft_affinity.
    - Clear solved. dir stays at its current value (N after reset).
  - ST_MV: strt_mv=1 for exactly one cycle → WT_MV.
  - WT_MV: wait for mv_cmplt → DECIDE. All inputs other than mv_cmplt are ignored here.
  - DECIDE: one cycle; evaluates inputs registered/sampled this cycle, first match wins.
    1. sol_cmplt → DONE.
    2. Preferred side open (lft_opn when left affinity, rght_opn when right) → turn that way, go to ST_HDNG.
    3. frwrd_opn → ST_MV; no heading change.
    4. Opposite side open → turn that way, go to ST_HDNG.
    5. Otherwise → reverse, go to ST_HDNG.
  - ST_HDNG: strt_hdng=1 for exactly one cycle. dsrd_hdng is already stable, having been updated on entry. → WT_HDNG.
  - WT_HDNG: wait for mv_cmplt → ST_MV.
  - DONE:
    - solved=1; stp_lft/stp_rght=0; no pulses.
    - strt_solve → ST_MV with the same actions as from IDLE; dir is retained.
- Latency:
  - strt_mv pulses in the cycle after strt_solve is accepted.
  - strt_hdng pulses 2 cycles after the mv_cmplt that triggered the turn (WT_MV→DECIDE→ST_HDNG).
  - strt_mv pulses 1 cycle after the mv_cmplt that ends a heading change.
- strt_hdng and strt_mv are never asserted in the same cycle, and each is never high more than 1 cycle consecutively.
- Simultaneous events:
  - strt_solve outside IDLE/DONE is ignored.
  - mv_cmplt outside WT_MV/WT_HDNG is ignored.
  - sol_cmplt has priority over every opening in DECIDE.
  - sol_cmplt outside DECIDE has no effect until the next DECIDE.
- Reset mid-operation: everything returns to reset values immediately (async). A pending navigator move is not tracked; mv_cmplt arriving afterward in IDLE is ignored.
- stp_lft/stp_rght are stable from acceptance until DONE or reset and never both 1.

Test Plan:
- Reset, then strt_solve with lft_affinity=1 → next cycle strt_mv=1 for 1 cycle; stp_lft=1, stp_rght=0, dsrd_hdng=12'h000, solved=0.
- Left affinity, dir=N, mv_cmplt with lft_opn=1, frwrd_opn=1 → dsrd_hdng=12'h3FF, strt_hdng pulse 2 cycles later. Then mv_cmplt → strt_mv pulse 1 cycle later.
- Left affinity, dir=N, mv_cmplt with lft_opn=0, frwrd_opn=1 → strt_mv pulse, no strt_hdng, dsrd_hdng stays 12'h000.
- Right affinity, dir=N, all openings 0 at mv_cmplt → dsrd_hdng=12'h7FF (reverse). Next dead end from S → 12'h000. Then rght_opn only, from N → 12'hC00.
- Wrap: left affinity, dir=E (12'hC00), lft_opn=1 → 12'h000. Right affinity, dir=N, rght_opn=1 → 12'hC00.
- sol_cmplt=1 with lft_opn=1 at mv_cmplt → DONE, solved=1, stp_lft=0, no pulses. strt_solve → solved=0, strt_mv pulse. Assert rst_n=0 mid-WT_HDNG → all outputs at reset values immediately.

Source files
------------

// File: rtl/maze_solve_if.sv
// rtl/maze_solve_if.sv - signal bundle between the maze solver, its sensors/start logic and the navigator
// Ports: none; signals only.
//   slave  modport: the solver (consumes start/IR/nav-done/solution, drives move commands and status)
//   master modport: the environment (drives start/IR/nav-done/solution, observes commands and status)
interface maze_solve_if;
    logic        strt_solve;
    logic        lft_affinity;
    logic        lft_opn;
    logic        rght_opn;
    logic        frwrd_opn;
    logic        mv_cmplt;
    logic        sol_cmplt;
    logic        strt_hdng;
    logic        strt_mv;
    logic        stp_lft;
    logic        stp_rght;
    logic [11:0] dsrd_hdng;
    logic        solved;

    modport slave (
        input  strt_solve, lft_affinity, lft_opn, rght_opn, frwrd_opn, mv_cmplt, sol_cmplt,
        output strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng, solved
    );

    modport master (
        output strt_solve, lft_affinity, lft_opn, rght_opn, frwrd_opn, mv_cmplt, sol_cmplt,
        input  strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng, solved
    );
endinterface

// File: rtl/maze_solve.sv
// rtl/maze_solve.sv - wall-following maze solver driving the navigation state machine
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : maze_solve_if.slave
//            in : strt_solve, lft_affinity, lft_opn, rght_opn, frwrd_opn, mv_cmplt, sol_cmplt
//            out: strt_hdng/strt_mv one-cycle pulses, stp_lft/stp_rght, dsrd_hdng[11:0], solved
module maze_solve #(
    parameter logic [11:0] HDNG_N = 12'h000,
    parameter logic [11:0] HDNG_W = 12'h3FF,
    parameter logic [11:0] HDNG_S = 12'h7FF,
    parameter logic [11:0] HDNG_E = 12'hC00
) (
    input  logic          clk,
    input  logic          rst_n,
    maze_solve_if.slave   bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ST_MV   = 3'd1;
    localparam logic [2:0] WT_MV   = 3'd2;
    localparam logic [2:0] DECIDE  = 3'd3;
    localparam logic [2:0] ST_HDNG = 3'd4;
    localparam logic [2:0] WT_HDNG = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [1:0]  dir_q, dir_d;          // 0=N 1=W 2=S 3=E; +1 is a left turn
    logic        aff_q, aff_d;          // 1 = left-wall follower
    logic        stp_lft_q, stp_lft_d;
    logic        stp_rght_q, stp_rght_d;
    logic        solved_q, solved_d;
    logic        strt_mv_q, strt_mv_d;
    logic        strt_hdng_q, strt_hdng_d;
    logic [11:0] dsrd_hdng_q, dsrd_hdng_d;

    logic [1:0]  dir_lft, dir_rght, dir_rev;
    logic        pref_opn, opp_opn;

    assign dir_lft  = dir_q + 2'd1;
    assign dir_rght = dir_q - 2'd1;
    assign dir_rev  = dir_q + 2'd2;
    assign pref_opn = aff_q ? bus.lft_opn  : bus.rght_opn;
    assign opp_opn  = aff_q ? bus.rght_opn : bus.lft_opn;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        aff_d      = aff_q;
        stp_lft_d  = stp_lft_q;
        stp_rght_d = stp_rght_q;
        solved_d   = solved_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.strt_solve) begin
                    state_d    = ST_MV;
                    aff_d      = bus.lft_affinity;
                    stp_lft_d  = bus.lft_affinity;
                    stp_rght_d = ~bus.lft_affinity;
                    solved_d   = 1'b0;
                end
            end
            ST_MV:   state_d = WT_MV;
            WT_MV:   if (bus.mv_cmplt) state_d = DECIDE;
            DECIDE: begin
                // Priority: solution, preferred wall side, straight, other side, U-turn.
                if (bus.sol_cmplt) begin
                    state_d    = DONE;
                    solved_d   = 1'b1;
                    stp_lft_d  = 1'b0;
                    stp_rght_d = 1'b0;
                end else if (pref_opn) begin
                    state_d = ST_HDNG;
                    dir_d   = aff_q ? dir_lft : dir_rght;
                end else if (bus.frwrd_opn) begin
                    state_d = ST_MV;
                end else if (opp_opn) begin
                    state_d = ST_HDNG;
                    dir_d   = aff_q ? dir_rght : dir_lft;
                end else begin
                    state_d = ST_HDNG;
                    dir_d   = dir_rev;
                end
            end
            ST_HDNG: state_d = WT_HDNG;
            WT_HDNG: if (bus.mv_cmplt) state_d = ST_MV;
            default: state_d = IDLE;
        endcase

        // Pulses are registered off the next state so they coincide with state entry.
        strt_mv_d   = (state_d == ST_MV);
        strt_hdng_d = (state_d == ST_HDNG);

        case (dir_d)
            2'd0:    dsrd_hdng_d = HDNG_N;
            2'd1:    dsrd_hdng_d = HDNG_W;
            2'd2:    dsrd_hdng_d = HDNG_S;
            default: dsrd_hdng_d = HDNG_E;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dir_q       <= 2'd0;
            aff_q       <= 1'b0;
            stp_lft_q   <= 1'b0;
            stp_rght_q  <= 1'b0;
            solved_q    <= 1'b0;
            strt_mv_q   <= 1'b0;
            strt_hdng_q <= 1'b0;
            dsrd_hdng_q <= HDNG_N;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            aff_q       <= aff_d;
            stp_lft_q   <= stp_lft_d;
            stp_rght_q  <= stp_rght_d;
            solved_q    <= solved_d;
            strt_mv_q   <= strt_mv_d;
            strt_hdng_q <= strt_hdng_d;
            dsrd_hdng_q <= dsrd_hdng_d;
        end
    end

    assign bus.strt_mv   = strt_mv_q;
    assign bus.strt_hdng = strt_hdng_q;
    assign bus.stp_lft   = stp_lft_q;
    assign bus.stp_rght  = stp_rght_q;
    assign bus.solved    = solved_q;
    assign bus.dsrd_hdng = dsrd_hdng_q;

endmodule

// File: tb/tb_maze_solve.sv
// tb/tb_maze_solve.sv - scoreboard bench for maze_solve with a navigator model and randomized maze openings
module tb_maze_solve;

    localparam int K_MV   = 0;
    localparam int K_HDNG = 1;
    localparam int K_DONE = 2;
    localparam int K_IDLE = 3;

    typedef struct {
        int          kind;
        logic [11:0] hdng;
        logic        sl;
        logic        sr;
        logic        sv;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    maze_solve_if ifc();

    maze_solve dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sbq[$];

    // reference model state
    int m_dir  = 0;
    bit m_aff  = 1'b0;
    int m_pend = K_IDLE;

    task automatic chk(input bit ok, input string name, input string info);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, info);
    endtask

    function automatic logic [11:0] hcode(input int d);
        case (d % 4)
            0:       return 12'h000;
            1:       return 12'h3FF;
            2:       return 12'h7FF;
            default: return 12'hC00;
        endcase
    endfunction

    task automatic push(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.hdng = hcode(m_dir);
        e.sl   = (kind == K_DONE) ? 1'b0 : m_aff;
        e.sr   = (kind == K_DONE) ? 1'b0 : !m_aff;
        e.sv   = (kind == K_DONE);
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic sb_check(input int k);
        exp_t e;
        if (sbq.size() == 0) begin
            chk(1'b0, "sb_unexpected", $sformatf("event kind %0d at cyc %0d with nothing expected", k, cyc));
        end else begin
            e = sbq.pop_front();
            chk(e.kind == k && e.hdng == ifc.dsrd_hdng && e.sl == ifc.stp_lft &&
                e.sr == ifc.stp_rght && e.sv == ifc.solved && e.cyc == cyc,
                "sb_event",
                $sformatf("got kind=%0d hdng=%h sl=%0b sr=%0b solved=%0b cyc=%0d, expected kind=%0d hdng=%h sl=%0b sr=%0b solved=%0b cyc=%0d",
                          k, ifc.dsrd_hdng, ifc.stp_lft, ifc.stp_rght, ifc.solved, cyc,
                          e.kind, e.hdng, e.sl, e.sr, e.sv, e.cyc));
        end
    endtask

    logic prev_mv = 1'b0, prev_hd = 1'b0, prev_sv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mv <= 1'b0;
            prev_hd <= 1'b0;
            prev_sv <= 1'b0;
        end else begin
            if (ifc.strt_mv || ifc.strt_hdng)
                chk(!(ifc.strt_mv && ifc.strt_hdng) && !(ifc.strt_mv && prev_mv) && !(ifc.strt_hdng && prev_hd),
                    "pulse_shape",
                    $sformatf("mv=%0b hd=%0b prev_mv=%0b prev_hd=%0b, required single isolated pulse",
                              ifc.strt_mv, ifc.strt_hdng, prev_mv, prev_hd));
            if (ifc.strt_mv)              sb_check(K_MV);
            if (ifc.strt_hdng)            sb_check(K_HDNG);
            if (ifc.solved && !prev_sv)   sb_check(K_DONE);
            prev_mv <= ifc.strt_mv;
            prev_hd <= ifc.strt_hdng;
            prev_sv <= ifc.solved;
        end
    end

    // ---------------- driver / navigator model ----------------
    task automatic check_reset_vals(input string name);
        chk(ifc.strt_hdng == 1'b0 && ifc.strt_mv == 1'b0 && ifc.stp_lft == 1'b0 &&
            ifc.stp_rght == 1'b0 && ifc.dsrd_hdng == 12'h000 && ifc.solved == 1'b0,
            name,
            $sformatf("hd=%0b mv=%0b sl=%0b sr=%0b hdng=%h solved=%0b, required all zero",
                      ifc.strt_hdng, ifc.strt_mv, ifc.stp_lft, ifc.stp_rght, ifc.dsrd_hdng, ifc.solved));
    endtask

    task automatic start(input bit aff);
        @(negedge clk);
        ifc.strt_solve   = 1'b1;
        ifc.lft_affinity = aff;
        ifc.sol_cmplt    = 1'b0;
        ifc.mv_cmplt     = 1'b0;
        m_aff  = aff;
        push(K_MV, cyc + 1);
        m_pend = K_MV;
        @(negedge clk);
        ifc.strt_solve = 1'b0;
    endtask

    task automatic wait_pulse();
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (ifc.strt_mv || ifc.strt_hdng) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(seen, "pulse_wait", $sformatf("no strt_mv/strt_hdng within 64 cycles at cyc %0d, required a pulse", cyc));
    endtask

    task automatic respond(input bit s, input bit l, input bit r, input bit f, input bit nz);
        int g;
        int issue;
        wait_pulse();
        g = $urandom_range(0, 2);
        repeat (g) begin
            @(negedge clk);
            if (nz) begin
                // inputs other than mv_cmplt are don't-care while waiting on the navigator
                ifc.lft_opn      = 1'($urandom);
                ifc.rght_opn     = 1'($urandom);
                ifc.frwrd_opn    = 1'($urandom);
                ifc.sol_cmplt    = 1'($urandom);
                ifc.lft_affinity = 1'($urandom);
                ifc.strt_solve   = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        ifc.strt_solve = 1'b0;
        ifc.mv_cmplt   = 1'b1;
        ifc.sol_cmplt  = s;
        ifc.lft_opn    = l;
        ifc.rght_opn   = r;
        ifc.frwrd_opn  = f;
        issue = cyc;
        if (m_pend == K_HDNG) begin
            push(K_MV, issue + 1);
            m_pend = K_MV;
        end else if (s) begin
            push(K_DONE, issue + 2);
            m_pend = K_DONE;
        end else if (m_aff ? l : r) begin
            m_dir = m_aff ? (m_dir + 1) % 4 : (m_dir + 3) % 4;
            push(K_HDNG, issue + 2);
            m_pend = K_HDNG;
        end else if (f) begin
            push(K_MV, issue + 2);
            m_pend = K_MV;
        end else if (m_aff ? r : l) begin
            m_dir = m_aff ? (m_dir + 3) % 4 : (m_dir + 1) % 4;
            push(K_HDNG, issue + 2);
            m_pend = K_HDNG;
        end else begin
            m_dir = (m_dir + 2) % 4;
            push(K_HDNG, issue + 2);
            m_pend = K_HDNG;
        end
        @(negedge clk);
        ifc.mv_cmplt = 1'b0;
    endtask

    initial begin
        ifc.strt_solve   = 1'b0;
        ifc.lft_affinity = 1'b0;
        ifc.lft_opn      = 1'b0;
        ifc.rght_opn     = 1'b0;
        ifc.frwrd_opn    = 1'b0;
        ifc.mv_cmplt     = 1'b0;
        ifc.sol_cmplt    = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_idle");

        // left affinity from N: left turn, straight move, then left turns wrapping E->N
        start(1'b1);
        respond(0, 1, 0, 1, 0);       // N -> W
        respond(0, 0, 0, 0, 0);       // heading done -> move
        respond(0, 0, 0, 1, 0);       // straight, heading unchanged
        respond(0, 1, 0, 0, 0);       // W -> S
        respond(0, 0, 0, 0, 0);
        respond(0, 1, 0, 0, 0);       // S -> E
        respond(0, 0, 0, 0, 0);
        respond(0, 1, 0, 0, 0);       // E -> N (wrap)
        respond(0, 0, 0, 0, 0);
        respond(1, 1, 0, 0, 0);       // solution beats open left
        repeat (3) @(negedge clk);

        // right affinity from retained N: dead ends and right wrap N -> E
        start(1'b0);
        respond(0, 0, 0, 0, 0);       // N -> S
        respond(0, 0, 0, 0, 0);
        respond(0, 0, 0, 0, 0);       // S -> N
        respond(0, 0, 0, 0, 0);
        respond(0, 0, 1, 0, 0);       // N -> E
        respond(0, 0, 0, 0, 0);

        // randomized maze walk
        for (int i = 0; i < 150; i++) begin
            if (m_pend == K_DONE || m_pend == K_IDLE) begin
                repeat (3) @(negedge clk);
                start(1'($urandom));
            end else begin
                respond(($urandom_range(0, 11) == 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end
        end

        // drive into WT_HDNG then reset asynchronously
        if (m_pend == K_DONE || m_pend == K_IDLE) begin
            repeat (3) @(negedge clk);
            start(1'b1);
        end
        if (m_pend == K_HDNG) respond(0, 0, 0, 0, 0);
        respond(0, 0, 0, 0, 0);       // dead end -> heading change
        wait_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        m_dir  = 0;
        m_pend = K_IDLE;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ifc.mv_cmplt = 1'b1;          // stale navigator completion in IDLE
        @(negedge clk);
        ifc.mv_cmplt = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_vals("idle_ignores_mv");

        start(1'b0);
        respond(0, 0, 1, 0, 0);       // right from N -> E
        wait_pulse();
        repeat (4) @(negedge clk);
        chk(sbq.size() == 0, "sb_drain", $sformatf("%0d expected events never seen, required 0", sbq.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
